// File: rtl/pcm_frame_tx.sv
// PCM telemetry frame transmitter: a sync word followed by DATA_WORDS data words,
// sent MSB first as NRZ with a bit clock that rises mid-bit.
module pcm_frame_tx #(
  parameter int                WORD_W     = 8,
  parameter int                DATA_WORDS = 4,
  parameter int                SYNC_W     = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 16'hEB90,
  parameter int                CLK_DIV    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              data_req_o,
  output logic              pcm_o,
  output logic              bit_clk_o,
  output logic              frame_sync_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BMAX = (SYNC_W > WORD_W) ? SYNC_W : WORD_W;
  localparam int BCW  = $clog2(BMAX + 1);
  localparam int WCW  = $clog2(DATA_WORDS + 1);
  localparam int PW   = $clog2(CLK_DIV);

  localparam logic [PW-1:0]   PH_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PH_HALF   = PW'(CLK_DIV / 2);
  localparam logic [BCW-1:0]  SYNC_LAST = BCW'(SYNC_W - 1);
  localparam logic [BCW-1:0]  WORD_LAST = BCW'(WORD_W - 1);
  localparam logic [BCW-1:0]  BIT_ONE   = BCW'(1);
  localparam logic [WCW-1:0]  LAST_WORD = WCW'(DATA_WORDS - 1);
  localparam logic [BMAX-1:0] SYNC_AL   = BMAX'(SYNC_WORD) << (BMAX - SYNC_W);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BCW-1:0]    bit_q, bit_d;     // bits remaining in the current field after this one
  logic [WCW-1:0]    word_q, word_d;
  logic [BMAX-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              cap_q, cap_d;
  logic              req_q, req_d;
  logic              bclk_q, bclk_d;
  logic              fsync_q, fsync_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    word_d  = word_q;
    shift_d = shift_q;
    hold_d  = cap_q ? data_i : hold_q;
    cap_d   = req_q;
    req_d   = 1'b0;
    bclk_d  = 1'b0;
    fsync_d = fsync_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SYNC;
          phase_d = '0;
          bit_d   = SYNC_LAST;
          word_d  = '0;
          shift_d = SYNC_AL;
          fsync_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SYNC, DATA: begin
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 1'b1;
          bclk_d  = (phase_d >= PH_HALF);
        end else begin
          phase_d = '0;
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            shift_d = shift_q << 1;
            // Ask for the next word as the last bit of this field goes out.
            req_d   = (bit_q == BIT_ONE) && ((state_q == SYNC) || (word_q != LAST_WORD));
          end else if (state_q == SYNC) begin
            state_d = DATA;
            fsync_d = 1'b0;
            bit_d   = WORD_LAST;
            word_d  = '0;
            shift_d = BMAX'(hold_q) << (BMAX - WORD_W);
          end else if (word_q == LAST_WORD) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
            word_d  = '0;
            shift_d = '0;
          end else begin
            word_d  = word_q + 1'b1;
            bit_d   = WORD_LAST;
            shift_d = BMAX'(hold_q) << (BMAX - WORD_W);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        fsync_d = 1'b0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      cap_q   <= 1'b0;
      req_q   <= 1'b0;
      bclk_q  <= 1'b0;
      fsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      cap_q   <= cap_d;
      req_q   <= req_d;
      bclk_q  <= bclk_d;
      fsync_q <= fsync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pcm_o        = shift_q[BMAX-1];
  assign data_req_o   = req_q;
  assign bit_clk_o    = bclk_q;
  assign frame_sync_o = fsync_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_pcm_frame_tx.sv
// Directed bench for pcm_frame_tx: default instance plus a CLK_DIV=6, 1x4-bit-word instance.
module tb_pcm_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  logic [7:0] data1;
  logic [3:0] data2;
  logic req1, pcm1, bclk1, fs1, busy1, done1;
  logic req2, pcm2, bclk2, fs2, busy2, done2;

  pcm_frame_tx u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .data_i(data1),
    .data_req_o(req1), .pcm_o(pcm1), .bit_clk_o(bclk1),
    .frame_sync_o(fs1), .busy_o(busy1), .done_o(done1)
  );

  pcm_frame_tx #(.WORD_W(4), .DATA_WORDS(1), .CLK_DIV(6)) u_dut6 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .data_i(data2),
    .data_req_o(req2), .pcm_o(pcm2), .bit_clk_o(bclk2),
    .frame_sync_o(fs2), .busy_o(busy2), .done_o(done2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc;
  int st1[$], st2[$];
  int rst_at;
  logic [7:0] src1[$];
  logic pend1, pend2;

  int req_q[$], done_q[$];
  logic [127:0] bits1;
  int nbits1, busy_cnt, busy_first, busy_last, fs_cnt, fs_first, fs_last, bhi_cnt;
  int last_rise, bad_sp;
  logic prev_b1;
  logic [3:0] probe203, probe204;

  int req2_q[$], done2_q[$];
  logic [31:0] bits2;
  int nbits2, busy2_cnt, bhi2_cnt;
  logic prev_b2;
  logic [6:0] b2_trace;

  task automatic clear_rec();
    req_q.delete(); done_q.delete(); req2_q.delete(); done2_q.delete();
    bits1 = '0; nbits1 = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
    fs_cnt = 0; fs_first = -1; fs_last = -1; bhi_cnt = 0;
    last_rise = -1; bad_sp = 0; prev_b1 = 1'b0;
    probe203 = '0; probe204 = '0;
    bits2 = '0; nbits2 = 0; busy2_cnt = 0; bhi2_cnt = 0; prev_b2 = 1'b0; b2_trace = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; cyc++;
      if (req1) req_q.push_back(cyc);
      if (done1) done_q.push_back(cyc);
      if (busy1) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc; busy_cnt++;
      end
      if (fs1) begin
        if (fs_first < 0) fs_first = cyc;
        fs_last = cyc; fs_cnt++;
      end
      if (bclk1) bhi_cnt++;
      if (bclk1 && !prev_b1) begin
        bits1 = {bits1[126:0], pcm1}; nbits1++;
        if (last_rise >= 0 && cyc - last_rise != 4) bad_sp++;
        last_rise = cyc;
      end
      prev_b1 = bclk1;
      if (done1) last_rise = -1;
      if (cyc == 203) probe203 = {busy1, done1, pcm1, bclk1};
      if (cyc == 204) probe204 = {busy1, fs1, pcm1, bclk1};

      if (req2) req2_q.push_back(cyc);
      if (done2) done2_q.push_back(cyc);
      if (busy2) busy2_cnt++;
      if (bclk2) bhi2_cnt++;
      if (bclk2 && !prev_b2) begin bits2 = {bits2[30:0], pcm2}; nbits2++; end
      prev_b2 = bclk2;
      if (cyc >= 6 && cyc <= 12) b2_trace = {b2_trace[5:0], bclk2};

      // Data is valid only in the cycle after the request.
      data1 = pend1 ? ((src1.size() > 0) ? src1.pop_front() : 8'h00) : 8'hC3;
      pend1 = req1;
      data2 = pend2 ? 4'h9 : 4'h6;
      pend2 = req2;
      start1 = 1'b0;
      foreach (st1[k]) if (st1[k] == cyc) start1 = 1'b1;
      start2 = 1'b0;
      foreach (st2[k]) if (st2[k] == cyc) start2 = 1'b1;
      if (cyc == rst_at) begin
        chk("busy_before_rst", busy1, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {pcm1, bclk1, fs1, busy1, done1, req1}, 6'b0);
        clear_rec();
        src1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        pend1 = 1'b0;
      end else begin
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; data1 = '0; data2 = '0;
    pend1 = 1'b0; pend2 = 1'b0; rst_at = -1;
    clear_rec();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pcm1, bclk1, fs1, busy1, done1, req1,
                          pcm2, bclk2, fs2, busy2, done2, req2}, 12'b0);
    rst = 1'b0;

    // Single frame with ignored re-starts; CLK_DIV=6 instance started at cycle 5.
    cyc = 0; clear_rec();
    st1 = '{10, 50, 120}; st2 = '{5};
    src1 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run(230);
    chk("a_bits", bits1[47:0], 48'hEB90A53CFF00);
    chk("a_nbits", nbits1, 48);
    chk("a_busy_first", busy_first, 11);
    chk("a_busy_last", busy_last, 202);
    chk("a_busy_cnt", busy_cnt, 192);
    chk("a_done_n", done_q.size(), 1);
    if (done_q.size() > 0) chk("a_done_cyc", done_q[0], 203);
    chk("a_req_n", req_q.size(), 4);
    for (int k = 0; k < 4 && k < req_q.size(); k++) chk("a_req_cyc", req_q[k], 71 + 32 * k);
    chk("a_fs_first", fs_first, 11);
    chk("a_fs_last", fs_last, 74);
    chk("a_fs_cnt", fs_cnt, 64);
    chk("a_bclk_high", bhi_cnt, 96);
    chk("a_bclk_period", bad_sp, 0);
    chk("b6_bits", bits2[19:0], 20'hEB909);
    chk("b6_nbits", nbits2, 20);
    chk("b6_busy_cnt", busy2_cnt, 120);
    chk("b6_done_n", done2_q.size(), 1);
    if (done2_q.size() > 0) chk("b6_done_cyc", done2_q[0], 126);
    chk("b6_req_n", req2_q.size(), 1);
    if (req2_q.size() > 0) chk("b6_req_cyc", req2_q[0], 96);
    chk("b6_bclk_high", bhi2_cnt, 60);
    chk("b6_bclk_phase", b2_trace, 7'b0001110);

    // Back-to-back: second start in the done cycle.
    cyc = 0; clear_rec(); st2.delete();
    st1 = '{10, 203};
    src1 = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    run(420);
    chk("bb_probe203", probe203, 4'b0100);
    chk("bb_probe204", probe204, 4'b1110);
    chk("bb_bits", bits1[95:0], 96'hEB90A53CFF00EB9012345678);
    chk("bb_busy_cnt", busy_cnt, 384);
    chk("bb_done_n", done_q.size(), 2);
    if (done_q.size() > 1) chk("bb_done2_cyc", done_q[1], 396);
    chk("bb_req_n", req_q.size(), 8);
    if (req_q.size() > 7) chk("bb_req_last", req_q[7], 360);
    chk("bb_bclk_period", bad_sp, 0);

    // Reset mid-DATA, then a fresh frame.
    cyc = 0; clear_rec();
    st1 = '{10, 100}; rst_at = 90;
    src1 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    run(320);
    rst_at = -1;
    chk("r_done_n", done_q.size(), 1);
    if (done_q.size() > 0) chk("r_done_cyc", done_q[0], 293);
    chk("r_req_n", req_q.size(), 4);
    for (int k = 0; k < 4 && k < req_q.size(); k++) chk("r_req_cyc", req_q[k], 161 + 32 * k);
    chk("r_bits", bits1[47:0], 48'hEB9011223344);
    chk("r_nbits", nbits1, 48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
